// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default geometry and state types.
package ram_arb_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned AW_DEFAULT = 6;
  localparam int unsigned DEPTH      = 2 ** AW_DEFAULT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/ram_arbiter_2p_ram.sv
// Single-port synchronous RAM with a registered read; contents are not reset.
module ram_sp_sync
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  // Write on we, and always register the addressed word for the read path.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter in front of one single-port RAM. After reset the RAM
// is cleared one word per cycle; afterwards requests are granted combinationally
// with a round-robin pointer that flips after every executed access.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | clear counter walks addresses 0..2**AW-1 writing zero; no grants
//   RUN   | arbitration active; terminal until the next reset
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          init_done
);

  // Counter is one bit wider than the address so the last clear address is
  // compared without the counter wrapping back to zero.
  localparam logic [AW:0] CLEAR_LAST = (AW + 1)'((2 ** AW) - 1);

  state_t        state;
  port_t         prio;
  logic [AW:0]   clear_cnt;
  logic          run;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;

  assign run   = (state == RUN);
  assign gnt_a = run && req_a && (!req_b || (prio == PORT_A));
  assign gnt_b = run && req_b && !gnt_a;

  // RAM port mux: clear counter while initialising, granted requester afterwards.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_a;
    ram_wdata = '0;
    if (!run) begin
      ram_we   = 1'b1;
      ram_addr = clear_cnt[AW-1:0];
    end else if (gnt_a) begin
      ram_we    = we_a;
      ram_addr  = addr_a;
      ram_wdata = wdata_a;
    end else if (gnt_b) begin
      ram_we    = we_b;
      ram_addr  = addr_b;
      ram_wdata = wdata_b;
    end
  end

  ram_sp_sync #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Sequencing FSM: clear the memory, then enter RUN and raise init_done together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clear_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == CLEAR_LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Round-robin pointer: after an executed access the other port gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PORT_A;
    end else if (gnt_a) begin
      prio <= PORT_B;
    end else if (gnt_b) begin
      prio <= PORT_A;
    end
  end

  // Delayed read grants: they mark which port owns the RAM output this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= gnt_a && !we_a;
      rvalid_b <= gnt_b && !we_b;
    end
  end

  // Keep each port's last read word so rdata holds while the RAM serves the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      if (rvalid_a) hold_a <= ram_rdata;
      if (rvalid_b) hold_b <= ram_rdata;
    end
  end

  assign rdata_a = rvalid_a ? ram_rdata : hold_a;
  assign rdata_b = rvalid_b ? ram_rdata : hold_b;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter_2p;
  import ram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic          we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
  logic [DW-1:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .init_done(init_done)
  );

  // Reference model: memory image, cycles spent clearing, priority and read returns.
  logic [DW-1:0] m_mem [0:DEPTH-1];
  int            m_clear = 0;
  logic          m_prio = 1'b0;
  logic          m_rva = 1'b0, m_rvb = 1'b0;
  logic [DW-1:0] m_rda = '0, m_rdb = '0;

  function automatic logic m_run();
    return m_clear == DEPTH;
  endfunction

  function automatic logic m_ga();
    return m_run() && req_a && (!req_b || !m_prio);
  endfunction

  function automatic logic m_gb();
    return m_run() && req_b && !m_ga();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear <= 0;
      m_prio  <= 1'b0;
      m_rva   <= 1'b0;
      m_rvb   <= 1'b0;
      m_rda   <= '0;
      m_rdb   <= '0;
    end else if (m_clear < DEPTH) begin
      m_clear <= m_clear + 1;
      m_rva   <= 1'b0;
      m_rvb   <= 1'b0;
      if (m_clear == DEPTH - 1)
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      m_rva <= m_ga() && !we_a;
      m_rvb <= m_gb() && !we_b;
      if (m_ga()) begin
        if (we_a) m_mem[addr_a] <= wdata_a;
        else      m_rda <= m_mem[addr_a];
        m_prio <= 1'b1;
      end else if (m_gb()) begin
        if (we_b) m_mem[addr_b] <= wdata_b;
        else      m_rdb <= m_mem[addr_b];
        m_prio <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      chk("init_done", {31'd0, init_done}, {31'd0, m_run()});
      chk("gnt_a", {31'd0, gnt_a}, {31'd0, m_ga()});
      chk("gnt_b", {31'd0, gnt_b}, {31'd0, m_gb()});
      chk("gnt_excl", {31'd0, gnt_a & gnt_b}, 32'd0);
      chk("rvalid_a", {31'd0, rvalid_a}, {31'd0, m_rva});
      chk("rvalid_b", {31'd0, rvalid_b}, {31'd0, m_rvb});
      chk("rdata_a", {24'd0, rdata_a}, {24'd0, m_rda});
      chk("rdata_b", {24'd0, rdata_b}, {24'd0, m_rdb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, 64);
  endtask

  logic [3:0] exp_seq;
  logic       deny_a = 1'b0, deny_b = 1'b0;

  initial begin
    #3 rst_n = 1'b0;
    #1 started = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Request held through the clear, then reads of cleared locations.
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd0;
    wait_init("init_latency_1");
    chk("gnt_a_first_run", {31'd0, gnt_a}, 32'd1);
    tick();
    chk("rd0_valid", {31'd0, rvalid_a}, 32'd1);
    chk("rd0_data", {24'd0, rdata_a}, 32'h00);
    addr_a = 6'd31;
    tick();
    chk("rd31_data", {24'd0, rdata_a}, 32'h00);
    addr_a = 6'd63;
    tick();
    chk("rd63_data", {24'd0, rdata_a}, 32'h00);

    // A writes, B reads the same address on the following cycle.
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 8'hA5;
    tick();
    req_a = 1'b0; we_a = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd5;
    #1;
    chk("raw_gnt_b", {31'd0, gnt_b}, 32'd1);
    tick();
    req_b = 1'b0;
    chk("raw_rvalid_b", {31'd0, rvalid_b}, 32'd1);
    chk("raw_rdata_b", {24'd0, rdata_b}, 32'hA5);
    tick();
    chk("raw_rvalid_b_pulse", {31'd0, rvalid_b}, 32'd0);
    chk("raw_rdata_b_hold", {24'd0, rdata_b}, 32'hA5);

    // A alone reads the same address back to back.
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; wdata_a = 8'h3C;
    tick();
    we_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b2b_gnt_a", {31'd0, gnt_a}, 32'd1);
      tick();
      chk("b2b_rvalid_a", {31'd0, rvalid_a}, 32'd1);
      chk("b2b_rdata_a", {24'd0, rdata_a}, 32'h3C);
    end
    req_a = 1'b0;
    tick();
    chk("b2b_rvalid_a_end", {31'd0, rvalid_a}, 32'd0);

    // Reset in the middle of the clear.
    apply_reset();
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_done", {31'd0, init_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init("init_latency_2");

    // Reset while a read is returning.
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd0; wdata_a = 8'h77;
    tick();
    we_a = 1'b0;
    tick();
    chk("inflight_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("inflight_rdata", {24'd0, rdata_a}, 32'h77);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    chk("rst_rdata_a", {24'd0, rdata_a}, 32'h00);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init("init_latency_3");

    // Continuous contention straight after reset: A,B,A,B.
    exp_seq = 4'b0101;
    req_a = 1'b1; req_b = 1'b1; addr_a = 6'd1; addr_b = 6'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("contend_gnt_a", {31'd0, gnt_a}, {31'd0, exp_seq[k]});
      chk("contend_gnt_b", {31'd0, gnt_b}, {31'd0, ~exp_seq[k]});
      tick();
      chk("contend_rvalid_a", {31'd0, rvalid_a}, {31'd0, exp_seq[k]});
      chk("contend_rvalid_b", {31'd0, rvalid_b}, {31'd0, ~exp_seq[k]});
    end
    idle_inputs();
    tick();

    // Random traffic on a narrow address window; denied requests are held.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        apply_reset();
        deny_a = 1'b0;
        deny_b = 1'b0;
      end
      if (!deny_a) begin
        req_a   = ($urandom_range(0, 3) != 0);
        we_a    = $urandom_range(0, 1) == 1;
        addr_a  = AW'($urandom_range(0, 7));
        wdata_a = DW'($urandom);
      end
      if (!deny_b) begin
        req_b   = ($urandom_range(0, 3) != 0);
        we_b    = $urandom_range(0, 1) == 1;
        addr_b  = AW'($urandom_range(0, 7));
        wdata_b = DW'($urandom);
      end
      #1;
      deny_a = req_a && !gnt_a && init_done;
      deny_b = req_b && !gnt_b && init_done;
      tick();
    end
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter_2p.md
RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 Parameter: DW, 8, data width in bits.
REQ-002 Parameter: AW, 6, address width in bits; memory depth SHALL be 2**AW (64).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req_a, req_b  input  1 each  access request from requester A / B.
REQ-006 Port: we_a, we_b  input  1 each  1 = write, 0 = read; qualified by req_x.
REQ-007 Port: addr_a, addr_b  input  AW each  access address.
REQ-008 Port: wdata_a, wdata_b  input  DW each  write data.
REQ-009 Port: gnt_a, gnt_b  output  1 each  combinational grant; access executes at the rising edge where req_x and gnt_x are both 1.
REQ-010 Port: rvalid_a, rvalid_b  output  1 each  one-cycle pulse marking valid read data.
REQ-011 Port: rdata_a, rdata_b  output  DW each  registered read data; held until the next read completes for that port.
REQ-012 Port: init_done  output  1  high once the post-reset memory clear is complete.

Function
REQ-013 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-014 INIT: a clear counter SHALL write 0 to addresses 0..2**AW-1, one per cycle, ascending; gnt_a and gnt_b SHALL stay 0.
REQ-015 After the write to address 2**AW-1, the FSM SHALL enter RUN and set init_done=1 on the next edge, so init_done rises exactly 64 cycles after reset release.
REQ-016 RUN is terminal; init_done SHALL stay 1 until the next reset.
REQ-017 In RUN, at most one of gnt_a and gnt_b SHALL be 1 in any cycle.
REQ-018 Single request: the requesting port SHALL be granted in the same cycle.
REQ-019 Both requesting: grant SHALL go to the port named by the priority pointer prio; prio resets to A.
REQ-020 After every executed access by port X, prio SHALL point to the other port; with no executed access, prio SHALL hold.
REQ-021 A denied request SHALL need no special handling: the requester keeps req high, unchanged, until granted; the arbiter stores no pending requests.
REQ-022 Granted write: memory[addr] SHALL update at that edge.
REQ-023 Granted read: memory[addr] SHALL be captured into rdata_x at that edge, with rvalid_x=1 for exactly the following cycle (latency 1).
REQ-024 Read after write, same address, any port, next cycle or later: the read SHALL return the newly written data, because accesses are serialized.
REQ-025 Same-address simultaneous requests SHALL be ordered by prio like any other contention.
REQ-026 Sustained two-port contention SHALL alternate grants A,B,A,B,... to give 50 % throughput each; one active port alone SHALL reach 100 %.
REQ-027 Address arithmetic: the clear counter SHALL be AW+1 bits so its terminal value is detected without wrap; AW-bit addresses need no bounds check.

Reset
REQ-028 Assertion of rst_n=0 SHALL, asynchronously: set state=INIT, clear counter=0, prio=A, init_done=0, rvalid_a=rvalid_b=0, rdata_a=rdata_b=0.
REQ-029 Reset mid-INIT or mid-RUN SHALL restart the clear from address 0; any in-flight read SHALL produce no rvalid.
REQ-030 Memory contents SHALL NOT be reset; the INIT clear defines them.

Structure
REQ-031 Package ram_arb_pkg SHALL hold: AW and DW defaults, DEPTH, and the state type {INIT, RUN}.
REQ-032 Storage SHALL be the sub-module ram_sp_sync: single-port synchronous RAM with clk, we, addr, wdata, rdata and a registered read. The arbiter SHALL drive its port through a mux (clear counter in INIT, granted requester in RUN).
REQ-033 Routing of rdata to rdata_a or rdata_b SHALL use a one-cycle-delayed copy of the grant.

Verification
REQ-034 Release reset with no requests -> init_done=1 exactly 64 cycles later; reads of addresses 0, 31 and 63 return 0x00.
REQ-035 req_a held during INIT -> gnt_a=0 throughout; gnt_a=1 in the first RUN cycle.
REQ-036 A writes 0xA5 to address 5, then B reads address 5 on the next cycle -> gnt_b=1, rvalid_b pulses one cycle later with rdata_b=0xA5.
REQ-037 Both ports request reads continuously for 4 cycles after reset -> grants A,B,A,B; rvalid alternates accordingly.
REQ-038 rst_n pulsed low at INIT count 30 -> outputs clear immediately; init_done rises 64 cycles after the new release.
REQ-039 A alone reads address 7 on 3 consecutive cycles -> gnt_a=1 every cycle; 3 back-to-back rvalid_a pulses.
